fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the asynchronous-read instruction memory.
- Owns the fetch PC and drives the memory word address.
- Captures the returned word together with its PC into a small in-order prefetch queue.
- Presents queue entries to decode over a valid/ready handshake, and supports a branch redirect that flushes the queue.

---
 rtl/fetch_unit.sv | 55 +++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns fetch PC, pushes {pc, imem_rd} into an in-order prefetch queue, presents head to decode over valid/ready, redirect flushes (clk, reset active-low async, imem_addr/imem_rd, redirect/redirect_pc, instr_valid/instr_ready/instr/instr_pc, fetch_done)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 4,
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_done
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  logic [31:0] pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0] ent_q [QDEPTH];
  logic [63:0] ent_d [QDEPTH];
  logic pop, push;
  assign imem_addr = pc_q;
  assign fetch_done = pc_q[31:2] >= 30'(MEM_WORDS);
  assign instr_valid = count_q != '0;
  assign {instr_pc, instr} = instr_valid ? ent_q[head_q] : 64'd0;
  always_comb begin
    pop = instr_valid & instr_ready & ~redirect;
    push = ~redirect & ~fetch_done & ((count_q < CW'(QDEPTH)) | pop);
    pc_d = redirect ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
    head_d = redirect ? '0 : head_q + AW'(pop);
    tail_d = redirect ? '0 : tail_q + AW'(push);
    count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    ent_d = ent_q;
    if (push) ent_d[tail_q] = {pc_q, imem_rd};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      pc_q <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) ent_q <= ent_d;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed corner sequences and random stimulus against a queue-based reference model
module tb_fetch_unit;
  logic clk = 0, reset = 0, redirect = 0, instr_ready = 0;
  logic [31:0] redirect_pc = 0;
  logic [31:0] imem_addr, imem_rd, instr, instr_pc;
  logic instr_valid, fetch_done;
  logic [31:0] mem [64];
  int nvec = 0, nmis = 0;
  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  ent_t mq[$];
  logic [31:0] mpc;
  typedef struct {
    logic rd; logic [31:0] rpc; logic rdy;
    logic ev; logic [31:0] epc; logic [31:0] ei; logic ed;
  } vec_t;
  vec_t tbl [8];
  always #5 clk = ~clk;
  assign imem_rd = (imem_addr[31:2] < 30'd64) ? mem[imem_addr[7:2]] : 32'hBAD0_BAD0;
  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .fetch_done(fetch_done)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %08h expected %08h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_check(input string tag);
    logic v;
    v = mq.size() != 0;
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    chk({tag, ".instr"}, instr, v ? mq[0].w : 32'd0);
    chk({tag, ".instr_pc"}, instr_pc, v ? mq[0].pc : 32'd0);
    chk({tag, ".imem_addr"}, imem_addr, mpc);
    chk({tag, ".done"}, 32'(fetch_done), 32'(mpc[31:2] >= 30'd64));
  endtask
  task automatic model_step();
    logic pop, can;
    if (redirect) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      pop = (mq.size() != 0) && instr_ready;
      can = (mpc[31:2] < 30'd64) && (mq.size() < 4 || pop);
      if (pop) void'(mq.pop_front());
      if (can) begin
        mq.push_back('{mpc, mem[mpc[7:2]]});
        mpc = mpc + 32'd4;
      end
    end
  endtask
  task automatic cyc(input logic rd, input logic [31:0] rpc, input logic rdy);
    redirect = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    @(negedge clk);
    model_check("model");
  endtask
  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 0;
    redirect = 0;
    instr_ready = 0;
    mq.delete();
    mpc = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'hE04F000F;
    mem[1] = 32'hF0813032;
    mem[2] = 32'hF0423021;
    mem[3] = 32'h11223344;
    mem[7] = 32'hF0835034;
    mem[8] = 32'h55667788;
    tbl[0] = '{0, 32'h0, 1, 0, 32'h00, 32'h0, 0};
    tbl[1] = '{0, 32'h0, 1, 1, 32'h00, 32'hE04F000F, 0};
    tbl[2] = '{0, 32'h0, 1, 1, 32'h04, 32'hF0813032, 0};
    tbl[3] = '{0, 32'h0, 1, 1, 32'h08, 32'hF0423021, 0};
    tbl[4] = '{1, 32'h1E, 1, 1, 32'h0C, 32'h11223344, 0};
    tbl[5] = '{0, 32'h0, 1, 0, 32'h00, 32'h0, 0};
    tbl[6] = '{0, 32'h0, 1, 1, 32'h1C, 32'hF0835034, 0};
    tbl[7] = '{0, 32'h0, 1, 1, 32'h20, 32'h55667788, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d.valid", i), 32'(instr_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.pc", i), instr_pc, tbl[i].epc);
      chk($sformatf("tbl%0d.instr", i), instr, tbl[i].ei);
      chk($sformatf("tbl%0d.done", i), 32'(fetch_done), 32'(tbl[i].ed));
      adv();
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0);
      if (i == 7) begin
        chk("bp.fetch_pc", imem_addr, 32'h10);
        chk("bp.instr_hold", instr, 32'hE04F000F);
      end
      adv();
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk($sformatf("drain%0d.pc", i), instr_pc, 32'(i * 4));
      chk($sformatf("drain%0d.valid", i), 32'(instr_valid), 32'd1);
      adv();
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0);
      adv();
    end
    cyc(1, 32'h1E, 1);
    adv();
    cyc(0, 0, 1);
    chk("redir.bubble", 32'(instr_valid), 32'd0);
    adv();
    cyc(0, 0, 1);
    chk("redir.pc", instr_pc, 32'h1C);
    chk("redir.instr", instr, 32'hF0835034);
    adv();
    cyc(1, 32'hF8, 1);
    adv();
    cyc(0, 0, 1);
    chk("eom.bubble", 32'(instr_valid), 32'd0);
    adv();
    cyc(0, 0, 1);
    chk("eom.pc_f8", instr_pc, 32'hF8);
    adv();
    cyc(0, 0, 1);
    chk("eom.pc_fc", instr_pc, 32'hFC);
    chk("eom.done", 32'(fetch_done), 32'd1);
    adv();
    cyc(0, 0, 1);
    chk("eom.empty", 32'(instr_valid), 32'd0);
    chk("eom.done_hold", 32'(fetch_done), 32'd1);
    adv();
    cyc(1, 32'h0, 1);
    adv();
    cyc(0, 0, 1);
    chk("eom.cleared", 32'(fetch_done), 32'd0);
    adv();
    cyc(0, 0, 1);
    chk("eom.resume", instr_pc, 32'h0);
    chk("eom.resume_v", 32'(instr_valid), 32'd1);
    adv();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      adv();
    end
    #3 reset = 0;
    #1;
    chk("arst.valid", 32'(instr_valid), 32'd0);
    chk("arst.instr", instr, 32'd0);
    chk("arst.pc", instr_pc, 32'd0);
    chk("arst.addr", imem_addr, 32'd0);
    mq.delete();
    mpc = 32'h0;
    @(posedge clk);
    #1 reset = 1;
    cyc(0, 0, 1);
    adv();
    cyc(0, 0, 1);
    chk("arst.restart", instr_pc, 32'h0);
    adv();
    for (int i = 0; i < 2000; i++) begin
      logic rd;
      logic [31:0] rpc;
      rd = $urandom_range(0, 19) == 0;
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 70) * 4 + $urandom_range(0, 3);
      cyc(rd, rpc, $urandom_range(0, 9) < 7);
      adv();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
